// File: rtl/apb2_pkg.sv
// Shared constants and FSM encoding for the two-requester APB2 arbiter.
package apb2_pkg;

   localparam int unsigned NUM_REQ = 2;
   localparam logic [2:0] PPROT_DEFAULT = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb2_state_e;

endpackage

// File: rtl/apb2_arbiter_if.sv
// Requester-side and APB2-side bundle of the arbiter; master = arbiter view.
interface apb2_arbiter_if
   import apb2_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ*STRB_WIDTH-1:0] req_strb;
   logic [NUM_REQ-1:0]            done;
   logic [DATA_WIDTH-1:0]         done_rdata;
   logic                          done_err;

   logic                          psel;
   logic                          penable;
   logic                          pwrite;
   logic [ADDR_WIDTH-1:0]         paddr;
   logic [DATA_WIDTH-1:0]         pwdata;
   logic [STRB_WIDTH-1:0]         pstrb;
   logic [2:0]                    pprot;
   logic [DATA_WIDTH-1:0]         prdata;
   logic                          pready;
   logic                          pslverr;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_strb,
      input  prdata, pready, pslverr,
      output done, done_rdata, done_err,
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_strb,
      output prdata, pready, pslverr,
      input  done, done_rdata, done_err,
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
   );

endinterface

// File: rtl/apb2_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances on grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic [1:0] grant_o
);
   // ptr_q names the requester that wins a tie.
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
         default: grant_o = 2'b00;
      endcase
      if (update_i && (grant_o != 2'b00)) begin
         ptr_d = grant_o[0];
      end else begin
         ptr_d = ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/apb2_arbiter.sv
// Two-requester APB2 master arbiter with round-robin grant and registered APB outputs.
// Optional ACCESS-phase timeout abort enabled by defining APB2_ARB_TIMEOUT_EN.
module apb2_arbiter
   import apb2_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   apb2_arbiter_if.master bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   apb2_state_e           state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
   logic [1:0]            done_q, done_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [1:0]            req_masked_s;
   logic [1:0]            grant_s;
   logic                  grant_en_s;
   logic                  sel_one_s;
`ifdef APB2_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]            cnt_q, cnt_d;
`endif

   // A requester is not re-arbitrated in the cycle its done pulse is visible.
   assign req_masked_s = bus.req_valid & ~done_q;
   assign sel_one_s    = (grant_s == 2'b10);

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req_masked_s),
      .update_i (grant_en_s),
      .grant_o  (grant_s)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      pstrb_d    = pstrb_q;
      done_d     = 2'b00;
      rdata_d    = '0;
      err_d      = 1'b0;
      grant_en_s = 1'b0;
`ifdef APB2_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_masked_s != 2'b00) begin
               grant_en_s = 1'b1;
               owner_d    = sel_one_s;
               pwrite_d   = sel_one_s ? bus.req_write[1] : bus.req_write[0];
               paddr_d    = sel_one_s ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                      : bus.req_addr[ADDR_WIDTH-1:0];
               pwdata_d   = sel_one_s ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                      : bus.req_wdata[DATA_WIDTH-1:0];
               pstrb_d    = sel_one_s ? bus.req_strb[2*STRB_WIDTH-1:STRB_WIDTH]
                                      : bus.req_strb[STRB_WIDTH-1:0];
               psel_d     = 1'b1;
               state_d    = ST_SETUP;
            end else begin
               psel_d     = 1'b0;
               penable_d  = 1'b0;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (bus.pready) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = owner_q ? 2'b10 : 2'b01;
               rdata_d   = pwrite_q ? '0 : bus.prdata;
               err_d     = bus.pslverr;
               state_d   = ST_IDLE;
`ifdef APB2_ARB_TIMEOUT_EN
               cnt_d     = 8'd0;
            end else if ((cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES)) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = owner_q ? 2'b10 : 2'b01;
               err_d     = 1'b1;
               state_d   = ST_IDLE;
               cnt_d     = 8'd0;
            end else begin
               cnt_d     = cnt_q + 8'd1;
            end
`else
            end else begin
               state_d   = ST_ACCESS;
            end
`endif
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         done_q    <= 2'b00;
         rdata_q   <= '0;
         err_q     <= 1'b0;
`ifdef APB2_ARB_TIMEOUT_EN
         cnt_q     <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
`ifdef APB2_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign bus.psel       = psel_q;
   assign bus.penable    = penable_q;
   assign bus.pwrite     = pwrite_q;
   assign bus.paddr      = paddr_q;
   assign bus.pwdata     = pwdata_q;
   assign bus.pstrb      = pstrb_q;
   assign bus.pprot      = PPROT_DEFAULT;
   assign bus.done       = done_q;
   assign bus.done_rdata = rdata_q;
   assign bus.done_err   = err_q;

endmodule
